// File: rtl/window_cfg_ctrl.sv
// Window comparator threshold controller: validates 6-byte UART threshold frames
// and reloads open/close atomically, then evaluates the registered window decision.
module window_cfg_ctrl #(
  parameter int                POS_W     = 11,
  parameter int                TIMEOUT   = 50000,
  parameter logic [POS_W-1:0]  OPEN_RST  = 11'd0,
  parameter logic [POS_W-1:0]  CLOSE_RST = 11'd2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [POS_W-1:0] coder,
  output logic [POS_W-1:0] open,
  output logic [POS_W-1:0] close,
  output logic             window,
  output logic             cfg_ok,
  output logic             cfg_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GOT_HDR = 3'd1,
    GOT_OH  = 3'd2,
    GOT_OL  = 3'd3,
    GOT_CH  = 3'd4,
    GOT_CL  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] open_stg_q, open_stg_d, close_stg_q, close_stg_d;
  logic [7:0]       xor_q, xor_d;
  logic             rsv_q, rsv_d;
  logic [POS_W-1:0] open_q, open_d, close_q, close_d;
  logic             window_q, ok_q, err_q;
  logic             ok_s, err_s, window_s;

  // Strict-compare window rule; open > close selects wrap mode.
  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] op,
                                     input logic [POS_W-1:0] cl);
    if (op > cl) begin
      in_window = !((pos > cl) && (pos < op));
    end else begin
      in_window = (pos > op) && (pos < cl);
    end
  endfunction

  // Frame FSM, staging, checksum, reserved flag and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    open_stg_d  = open_stg_q;
    close_stg_d = close_stg_q;
    xor_d       = xor_q;
    rsv_d       = rsv_q;
    open_d      = open_q;
    close_d     = close_q;
    ok_s        = 1'b0;
    err_s       = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == HDR) begin
            state_d = GOT_HDR;
            xor_d   = 8'h00;
            rsv_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        GOT_HDR: begin
          open_stg_d = POS_W'({rx_data[2:0], open_stg_q[7:0]});
          xor_d      = xor_q ^ rx_data;
          rsv_d      = rsv_q | (|rx_data[7:3]);
          state_d    = GOT_OH;
        end
        GOT_OH: begin
          open_stg_d = POS_W'({open_stg_q[10:8], rx_data});
          xor_d      = xor_q ^ rx_data;
          state_d    = GOT_OL;
        end
        GOT_OL: begin
          close_stg_d = POS_W'({rx_data[2:0], close_stg_q[7:0]});
          xor_d       = xor_q ^ rx_data;
          rsv_d       = rsv_q | (|rx_data[7:3]);
          state_d     = GOT_CH;
        end
        GOT_CH: begin
          close_stg_d = POS_W'({close_stg_q[10:8], rx_data});
          xor_d       = xor_q ^ rx_data;
          state_d     = GOT_CL;
        end
        GOT_CL: begin
          state_d = IDLE;
          if ((rx_data == xor_q) && !rsv_q) begin
            open_d  = open_stg_q;
            close_d = close_stg_q;
            ok_s    = 1'b1;
          end else begin
            err_s   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if ((state_q != IDLE) && (cnt_q == TO_VAL)) begin
      state_d     = IDLE;
      open_stg_d  = {POS_W{1'b0}};
      close_stg_d = {POS_W{1'b0}};
      err_s       = 1'b1;
    end else begin
      state_d = state_q;
    end
    // The count only runs while a frame is open; any accepted byte restarts it.
    if (rx_valid || (state_d == IDLE)) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    window_s = in_window(coder, open_q, close_q);
  end

  // State, staging and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      open_stg_q  <= {POS_W{1'b0}};
      close_stg_q <= {POS_W{1'b0}};
      xor_q       <= 8'h00;
      rsv_q       <= 1'b0;
      open_q      <= OPEN_RST;
      close_q     <= CLOSE_RST;
      window_q    <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      open_stg_q  <= open_stg_d;
      close_stg_q <= close_stg_d;
      xor_q       <= xor_d;
      rsv_q       <= rsv_d;
      open_q      <= open_d;
      close_q     <= close_d;
      window_q    <= window_s;
      ok_q        <= ok_s;
      err_q       <= err_s;
    end
  end

  assign open    = open_q;
  assign close   = close_q;
  assign window  = window_q;
  assign cfg_ok  = ok_q;
  assign cfg_err = err_q;

endmodule
